// File: rtl/data_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl_if
//   Request/response bus between the CPU control FSM (master) and the data
//   memory controller (slave).
//
//   Req       master->slave  request strobe, sampled only while the slave is idle
//   We        master->slave  1 = store, 0 = load
//   Size      master->slave  00 byte, 01 halfword, 10 word, 11 reserved
//   Sign_ext  master->slave  sub-word loads: 1 = sign-extend, 0 = zero-extend
//   Addr      master->slave  byte address (ADDR_W bits)
//   WData     master->slave  store data, right-justified for sub-word stores
//   RData     slave->master  load result, non-zero only in the Ready cycle
//   Ready     slave->master  one-cycle completion pulse
//   Busy      slave->master  request in flight
//   Addr_err  slave->master  misalignment flag, qualified by Ready
// ---------------------------------------------------------------------------
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic              Req;
    logic              We;
    logic [1:0]        Size;
    logic              Sign_ext;
    logic [ADDR_W-1:0] Addr;
    logic [31:0]       WData;
    logic [31:0]       RData;
    logic              Ready;
    logic              Busy;
    logic              Addr_err;

    modport master (
        output Req, We, Size, Sign_ext, Addr, WData,
        input  RData, Ready, Busy, Addr_err
    );

    modport slave (
        input  Req, We, Size, Sign_ext, Addr, WData,
        output RData, Ready, Busy, Addr_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
//   Data memory for the multi-cycle MIPS CPU: 2**(ADDR_W-2) x 32-bit words with
//   byte / halfword / word access, sign or zero extension on loads, selectable
//   endianness and WAIT_STATES idle cycles before each array access.
//
//   Ports
//     CLK    clock, all state changes on the rising edge
//     Rst_n  asynchronous active-low reset
//     bus    data_mem_ctrl_if.slave (Req/We/Size/Sign_ext/Addr/WData in,
//            RData/Ready/Busy/Addr_err out)
//
//   Parameters
//     ADDR_W       byte-address width
//     WAIT_STATES  extra cycles before the array access (0..15)
//     BIG_ENDIAN   1: byte offset 0 is bits[31:24]; 0: byte offset 0 is bits[7:0]
//
//   Build option
//     DMEM_ALIGN_EXC_EN  when defined, misaligned or reserved-size requests run
//                        the full latency without touching the array and report
//                        Addr_err=1 with RData=0. When undefined, Addr_err is 0,
//                        unused low address bits are ignored and Size=11 acts
//                        as a word access.
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int ADDR_W      = 14,
    parameter int WAIT_STATES = 1,
    parameter bit BIG_ENDIAN  = 1'b1
) (
    input  logic          CLK,
    input  logic          Rst_n,
    data_mem_ctrl_if.slave bus
);
    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    state_t state, state_nxt;

    logic [3:0]        wait_cnt;
    logic              we_q;
    logic              sign_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [31:0] mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [1:0]       byte_lane;
    logic             half_hi;
    logic [3:0]       byte_en;
    logic [31:0]      wr_word;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_val;
    logic             misaligned;
    logic             accept;
    logic             in_access;

    assign accept    = (state == S_IDLE) && bus.Req;
    assign in_access = (state == S_ACCESS);
    assign bus.Busy  = (state != S_IDLE);

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default first so no path through the case can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.Req) begin
                    state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Request capture and wait counter. Inputs are frozen on acceptance so the
    // requester may change them freely while the operation is in flight.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            wait_cnt <= 4'd0;
            we_q     <= 1'b0;
            sign_q   <= 1'b0;
            size_q   <= SZ_BYTE;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            wait_cnt <= WAIT_INIT;
            we_q     <= bus.We;
            sign_q   <= bus.Sign_ext;
            size_q   <= bus.Size;
            addr_q   <= bus.Addr;
            wdata_q  <= bus.WData;
        end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Alignment policy
    // -----------------------------------------------------------------------
`ifdef DMEM_ALIGN_EXC_EN
    assign misaligned = ((size_q == SZ_HALF) && addr_q[0])
                      | ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00))
                      | (size_q == SZ_RSVD);
`else
    // Word accesses never look at Addr[1:0] and halfword accesses only look
    // at Addr[1], so the low bits are implicitly forced to zero below.
    assign misaligned = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Lane selection. byte_lane / half_hi name the physical bit position of
    // the addressed byte / halfword inside the 32-bit word.
    // -----------------------------------------------------------------------
    assign idx       = addr_q[ADDR_W-1:2];
    assign byte_lane = BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0];
    assign half_hi   = BIG_ENDIAN ? ~addr_q[1]   : addr_q[1];

    always_comb begin
        byte_en = 4'b1111;
        wr_word = wdata_q;
        case (size_q)
            SZ_BYTE: begin
                byte_en = 4'b0001 << byte_lane;
                wr_word = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                byte_en = half_hi ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_q[15:0]}};
            end
            default: begin
                // Word, and the reserved size when it is not trapped.
                byte_en = 4'b1111;
                wr_word = wdata_q;
            end
        endcase
    end

    assign rd_word = mem[idx];
    assign rd_byte = rd_word[{byte_lane, 3'b000} +: 8];
    assign rd_half = half_hi ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = rd_word;
        case (size_q)
            SZ_BYTE: load_val = {{24{sign_q & rd_byte[7]}}, rd_byte};
            SZ_HALF: load_val = {{16{sign_q & rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // -----------------------------------------------------------------------
    // Storage array. A reset asserted before the ACCESS-ending edge forces the
    // FSM to IDLE, which is enough to suppress the write.
    // -----------------------------------------------------------------------
    // NOTE: the array has no reset so it maps onto RAM; its contents survive
    // Rst_n and are undefined after power-up.
    always_ff @(posedge CLK) begin
        if (in_access && we_q && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Response registers, updated on the edge that ends ACCESS. RData is
    // cleared in every other cycle so the read bus only carries load results.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            bus.Ready    <= 1'b0;
            bus.RData    <= '0;
            bus.Addr_err <= 1'b0;
        end else begin
            bus.Ready    <= in_access;
            bus.Addr_err <= in_access && misaligned;
            bus.RData    <= (in_access && !we_q && !misaligned) ? load_val : 32'd0;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
//   Two instances share clock and reset:
//     dut1  WAIT_STATES=1, BIG_ENDIAN=1  (main configuration)
//     dut0  WAIT_STATES=0, BIG_ENDIAN=0  (zero-wait latency, little endian)
//   Drivers push the expected response and Ready cycle into a per-instance
//   queue; independent monitors pop and compare whenever Ready is seen.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;

    logic CLK   = 1'b0;
    logic Rst_n = 1'b0;

    always #5 CLK = ~CLK;

    data_mem_ctrl_if #(.ADDR_W(14)) bus1 ();
    data_mem_ctrl_if #(.ADDR_W(14)) bus0 ();

    data_mem_ctrl #(.ADDR_W(14), .WAIT_STATES(1), .BIG_ENDIAN(1'b1)) dut1 (
        .CLK   (CLK),
        .Rst_n (Rst_n),
        .bus   (bus1.slave)
    );

    data_mem_ctrl #(.ADDR_W(14), .WAIT_STATES(0), .BIG_ENDIAN(1'b0)) dut0 (
        .CLK   (CLK),
        .Rst_n (Rst_n),
        .bus   (bus0.slave)
    );

`ifdef DMEM_ALIGN_EXC_EN
    localparam bit EXC = 1'b1;
`else
    localparam bit EXC = 1'b0;
`endif

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;
    localparam logic [1:0] R = 2'b11;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];
    exp_t e1, e0;

    int  cyc      = 0;
    int  tests    = 0;
    int  fails    = 0;
    bit  chk_busy = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- monitors
    always @(negedge CLK) begin
        if (Rst_n) begin
            if (bus1.Ready) begin
                if (q1.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ready1: actual Ready=1 required no response (cycle %0d)", cyc);
                end else begin
                    e1 = q1.pop_front();
                    check("rdata1",    bus1.RData,    e1.rdata);
                    check("addr_err1", {31'd0, bus1.Addr_err}, {31'd0, e1.err});
                    check("ready_cyc1", cyc,          e1.cyc);
                    check("busy_in_ready1", {31'd0, bus1.Busy}, 32'd0);
                end
            end else begin
                check("rdata_idle1", bus1.RData, 32'd0);
            end
            if (chk_busy) begin
                check("busy_b2b", {31'd0, bus1.Busy}, {31'd0, !bus1.Ready});
            end
        end
    end

    always @(negedge CLK) begin
        if (Rst_n && bus0.Ready) begin
            if (q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ready0: actual Ready=1 required no response (cycle %0d)", cyc);
            end else begin
                e0 = q0.pop_front();
                check("rdata0",    bus0.RData,    e0.rdata);
                check("addr_err0", {31'd0, bus0.Addr_err}, {31'd0, e0.err});
                check("ready_cyc0", cyc,          e0.cyc);
            end
        end
    end

    // ----------------------------------------------------------------- drivers
    task automatic drive(input int d, input logic we, input logic [1:0] size, input logic sx,
                         input logic [13:0] addr, input logic [31:0] wdata);
        if (d == 1) begin
            bus1.Req = 1'b1; bus1.We = we; bus1.Size = size; bus1.Sign_ext = sx;
            bus1.Addr = addr; bus1.WData = wdata;
        end else begin
            bus0.Req = 1'b1; bus0.We = we; bus0.Size = size; bus0.Sign_ext = sx;
            bus0.Addr = addr; bus0.WData = wdata;
        end
    endtask

    // Drops Req and scrambles the other inputs; the DUT must have latched them.
    task automatic drop(input int d);
        if (d == 1) begin
            bus1.Req = 1'b0; bus1.We = ~bus1.We; bus1.Size = ~bus1.Size;
            bus1.Sign_ext = ~bus1.Sign_ext; bus1.Addr = 14'h3FFC; bus1.WData = 32'h5A5A_5A5A;
        end else begin
            bus0.Req = 1'b0; bus0.We = ~bus0.We; bus0.Size = ~bus0.Size;
            bus0.Sign_ext = ~bus0.Sign_ext; bus0.Addr = 14'h3FFC; bus0.WData = 32'h5A5A_5A5A;
        end
    endtask

    task automatic push(input int d, input logic [31:0] rdata, input logic err, input int at);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.cyc   = at;
        if (d == 1) q1.push_back(e);
        else        q0.push_back(e);
    endtask

    task automatic wait_ready(input int d, input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if ((d == 1) ? bus1.Ready : bus0.Ready) return;
        end
        tests++;
        fails++;
        $display("FAIL timeout_%s: actual no Ready within 40 cycles required Ready", name);
    endtask

    task automatic op(input int d, input string name, input logic we, input logic [1:0] size,
                      input logic sx, input logic [13:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
        @(posedge CLK); #1;
        drive(d, we, size, sx, addr, wdata);
        push(d, exp_rdata, exp_err, cyc + ((d == 1) ? 3 : 2));
        @(posedge CLK); #1;
        drop(d);
        wait_ready(d, name);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int n;
        bus1.Req = 0; bus1.We = 0; bus1.Size = 0; bus1.Sign_ext = 0; bus1.Addr = 0; bus1.WData = 0;
        bus0.Req = 0; bus0.We = 0; bus0.Size = 0; bus0.Sign_ext = 0; bus0.Addr = 0; bus0.WData = 0;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ready",    {31'd0, bus1.Ready},    32'd0);
        check("rst_rdata",    bus1.RData,             32'd0);
        check("rst_busy",     {31'd0, bus1.Busy},     32'd0);
        check("rst_addr_err", {31'd0, bus1.Addr_err}, 32'd0);
        @(negedge CLK);
        Rst_n = 1'b1;

        // 1: word store / load
        op(1, "sw010", 1, W, 0, 14'h010, 32'hDEAD_BEEF, 32'h0, 0);
        op(1, "lw010", 0, W, 0, 14'h010, 32'h0,         32'hDEAD_BEEF, 0);

        // 2: byte store, loads with and without extension
        op(1, "sb011",  1, B, 0, 14'h011, 32'h0000_00A5, 32'h0, 0);
        op(1, "lw010b", 0, W, 1, 14'h010, 32'h0, 32'hDEA5_BEEF, 0);
        op(1, "lb011",  0, B, 1, 14'h011, 32'h0, 32'hFFFF_FFA5, 0);
        op(1, "lbu011", 0, B, 0, 14'h011, 32'h0, 32'h0000_00A5, 0);

        // 3: halfword store, loads with and without extension
        op(1, "sh012",  1, H, 0, 14'h012, 32'h0000_8001, 32'h0, 0);
        op(1, "lw010h", 0, W, 0, 14'h010, 32'h0, 32'hDEA5_8001, 0);
        op(1, "lh012",  0, H, 1, 14'h012, 32'h0, 32'hFFFF_8001, 0);
        op(1, "lhu012", 0, H, 0, 14'h012, 32'h0, 32'h0000_8001, 0);

        // 4a: Req held high for three back-to-back loads
        @(posedge CLK); #1;
        drive(1, 0, W, 0, 14'h010, 32'h0);
        push(1, 32'hDEA5_8001, 0, cyc + 3);
        push(1, 32'hDEA5_8001, 0, cyc + 6);
        push(1, 32'hDEA5_8001, 0, cyc + 9);
        @(posedge CLK); #1;
        chk_busy = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 2; i++) begin
            @(negedge CLK);
            if (bus1.Ready) n++;
        end
        @(posedge CLK); #1;
        drop(1);
        wait_ready(1, "b2b");
        chk_busy = 1'b0;

        // 4b: Req pulsed while Busy must not start another operation
        @(posedge CLK); #1;
        drive(1, 0, B, 0, 14'h012, 32'h0);
        push(1, 32'h0000_0080, 0, cyc + 3);
        @(posedge CLK); #1;
        drive(1, 0, W, 0, 14'h000, 32'h0);
        @(posedge CLK); #1;
        drive(1, 1, W, 0, 14'h010, 32'hFFFF_FFFF);
        @(posedge CLK); #1;
        drop(1);
        wait_ready(1, "pulse");
        repeat (5) @(negedge CLK);
        check("no_extra_ready", q1.size(), 32'd0);

        // 4c: zero wait states, little endian
        op(0, "sw040",  1, W, 0, 14'h040, 32'h8899_AABB, 32'h0, 0);
        op(0, "lb041",  0, B, 1, 14'h041, 32'h0, 32'hFFFF_FFAA, 0);
        op(0, "lhu042", 0, H, 0, 14'h042, 32'h0, 32'h0000_8899, 0);
        op(0, "lh040",  0, H, 1, 14'h040, 32'h0, 32'hFFFF_AABB, 0);
        op(0, "sb043",  1, B, 0, 14'h043, 32'h0000_0011, 32'h0, 0);
        op(0, "lw040",  0, W, 0, 14'h040, 32'h0, 32'h1199_AABB, 0);

        // 5: reset during WAIT aborts the store
        op(1, "sw020", 1, W, 0, 14'h020, 32'h0BAD_F00D, 32'h0, 0);
        @(posedge CLK); #1;
        drive(1, 1, W, 0, 14'h020, 32'h1234_5678);
        @(posedge CLK); #1;
        drop(1);
        check("busy_wait", {31'd0, bus1.Busy}, 32'd1);
        #2 Rst_n = 1'b0;
        #1;
        check("abort_ready",    {31'd0, bus1.Ready},    32'd0);
        check("abort_rdata",    bus1.RData,             32'd0);
        check("abort_busy",     {31'd0, bus1.Busy},     32'd0);
        check("abort_addr_err", {31'd0, bus1.Addr_err}, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        Rst_n = 1'b1;
        op(1, "lw020", 0, W, 0, 14'h020, 32'h0, 32'h0BAD_F00D, 0);

        // 6: misaligned and reserved-size accesses
        op(1, "lw013",  0, W, 0, 14'h013, 32'h0,
           EXC ? 32'h0 : 32'hDEA5_8001, EXC);
        op(1, "sw012",  1, W, 0, 14'h012, 32'hCAFE_F00D, 32'h0, EXC);
        op(1, "lw010m", 0, W, 0, 14'h010, 32'h0,
           EXC ? 32'hDEA5_8001 : 32'hCAFE_F00D, 0);
        op(1, "lrsv",   0, R, 1, 14'h010, 32'h0,
           EXC ? 32'h0 : 32'hCAFE_F00D, EXC);
        op(1, "lh011",  0, H, 1, 14'h011, 32'h0,
           EXC ? 32'h0 : 32'hFFFF_CAFE, EXC);

        repeat (3) @(negedge CLK);
        check("q1_drained", q1.size(), 32'd0);
        check("q0_drained", q0.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual simulation still running required completion");
        $fatal(1, "global timeout");
    end

endmodule
